// File: rtl/taxi_pcie_msix_rx.sv
// MSI-X doorbell receiver.
// Consumes inbound memory-write TLPs. A single-DW write of an in-range
// vector number to the configured doorbell address becomes one entry on the
// m_axis_irq stream. Every other TLP is swallowed and flagged on stat_drop.
module taxi_pcie_msix_rx #(
  parameter int IRQ_INDEX_W = 11,
  parameter int FIFO_DEPTH  = 16,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic [127:0]           rx_wr_req_tlp_hdr,
  input  logic [DATA_W-1:0]      rx_wr_req_tlp_data,
  input  logic                   rx_wr_req_tlp_sop,
  input  logic                   rx_wr_req_tlp_eop,
  input  logic                   rx_wr_req_tlp_valid,
  output logic                   rx_wr_req_tlp_ready,

  output logic [IRQ_INDEX_W-1:0] m_axis_irq_tdata,
  output logic                   m_axis_irq_tvalid,
  output logic                   m_axis_irq_tlast,
  input  logic                   m_axis_irq_tready,

  input  logic [63:0]            db_addr,
  input  logic                   db_enable,

  output logic                   stat_irq,
  output logic                   stat_drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    ST_IDLE,
    ST_DROP
  } state_t;

  // Full doorbell qualification of one sop beat.
  function automatic logic is_doorbell(
    input logic [127:0] hdr,
    input logic [31:0]  payload,
    input logic [63:0]  target,
    input logic         enable,
    input logic         sop,
    input logic         eop
  );
    logic [7:0]  fmt_type;
    logic [63:0] addr;
    logic        fmt_ok;
    fmt_type = hdr[127:120];
    fmt_ok   = (fmt_type == 8'h40) || (fmt_type == 8'h60);
    if (fmt_type == 8'h60)
      addr = {hdr[63:32], hdr[31:2], 2'b00};
    else
      addr = {32'h0, hdr[63:34], 2'b00};
    return enable && fmt_ok && sop && eop &&
           (hdr[105:96] == 10'd1) &&
           (hdr[67:64] == 4'hF) && (hdr[71:68] == 4'h0) &&
           (addr[63:2] == target[63:2]) &&
           ((payload >> IRQ_INDEX_W) == 32'd0);
  endfunction

  state_t                 state;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [IRQ_INDEX_W-1:0] mem [FIFO_DEPTH];

  logic                   xfer;
  logic                   sop_beat;
  logic                   hit;
  logic                   push;
  logic                   pop;
  logic                   miss;
  logic                   fifo_empty;
  logic [PW-1:0]          wr_next;
  logic [PW-1:0]          rd_next;
  logic                   full_next;
  logic                   unused_bits;

  assign xfer     = rx_wr_req_tlp_valid && rx_wr_req_tlp_ready;
  assign sop_beat = xfer && (state == ST_IDLE) && rx_wr_req_tlp_sop;
  assign hit      = sop_beat && is_doorbell(rx_wr_req_tlp_hdr, rx_wr_req_tlp_data[31:0],
                                            db_addr, db_enable,
                                            rx_wr_req_tlp_sop, rx_wr_req_tlp_eop);
  assign push     = hit;
  assign miss     = sop_beat && !hit;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign pop        = m_axis_irq_tvalid && m_axis_irq_tready;

  // ready is registered from the post-update pointers so it drops the cycle
  // right after the filling push and never depends on tready combinationally.
  assign wr_next   = wr_ptr + PW'(push);
  assign rd_next   = rd_ptr + PW'(pop);
  assign full_next = (wr_next[AW] != rd_next[AW]) &&
                     (wr_next[AW-1:0] == rd_next[AW-1:0]);

  // Head of the FIFO drives the stream; tdata is held at zero while empty.
  assign m_axis_irq_tvalid = !fifo_empty;
  assign m_axis_irq_tdata  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign m_axis_irq_tlast  = 1'b1;

  // Header fields and data bits not involved in doorbell qualification.
  assign unused_bits = ^{rx_wr_req_tlp_hdr[119:106], rx_wr_req_tlp_hdr[95:72],
                         rx_wr_req_tlp_data};

  // Vector storage; holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= rx_wr_req_tlp_data[IRQ_INDEX_W-1:0];
  end

  // FIFO pointers and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      rx_wr_req_tlp_ready <= 1'b0;
    end else begin
      wr_ptr              <= wr_next;
      rd_ptr              <= rd_next;
      rx_wr_req_tlp_ready <= !full_next;
    end
  end

  // TLP framing FSM with registered statistic pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      stat_irq  <= 1'b0;
      stat_drop <= 1'b0;
    end else begin
      stat_irq  <= push;
      stat_drop <= miss;
      case (state)
        ST_IDLE: if (miss && !rx_wr_req_tlp_eop) state <= ST_DROP;
        ST_DROP: if (xfer && rx_wr_req_tlp_eop)  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_taxi_pcie_msix_rx.sv
// Directed bench for the MSI-X doorbell receiver.
module tb_taxi_pcie_msix_rx;

  localparam int IRQ_INDEX_W = 11;
  localparam logic [63:0] DB = 64'h0000_0000_FEE0_1000;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [127:0]           hdr = '0;
  logic [31:0]            data = '0;
  logic                   sop = 1'b0;
  logic                   eop = 1'b0;
  logic                   valid = 1'b0;
  logic                   ready;
  logic [IRQ_INDEX_W-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready = 1'b0;
  logic [63:0]            db_addr = DB;
  logic                   db_enable = 1'b1;
  logic                   stat_irq;
  logic                   stat_drop;

  int n_vec = 0;
  int n_err = 0;

  // Monitor state (written only by the monitor process).
  int irq_cnt = 0;
  int drop_cnt = 0;
  int out_n = 0;
  logic [IRQ_INDEX_W-1:0] out_log [256];

  always #5 clk = ~clk;

  taxi_pcie_msix_rx #(
    .IRQ_INDEX_W(IRQ_INDEX_W),
    .FIFO_DEPTH (16),
    .DATA_W     (32)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rx_wr_req_tlp_hdr   (hdr),
    .rx_wr_req_tlp_data  (data),
    .rx_wr_req_tlp_sop   (sop),
    .rx_wr_req_tlp_eop   (eop),
    .rx_wr_req_tlp_valid (valid),
    .rx_wr_req_tlp_ready (ready),
    .m_axis_irq_tdata    (tdata),
    .m_axis_irq_tvalid   (tvalid),
    .m_axis_irq_tlast    (tlast),
    .m_axis_irq_tready   (tready),
    .db_addr             (db_addr),
    .db_enable           (db_enable),
    .stat_irq            (stat_irq),
    .stat_drop           (stat_drop)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (stat_irq)  irq_cnt  = irq_cnt + 1;
      if (stat_drop) drop_cnt = drop_cnt + 1;
      if (tvalid && tready && out_n < 256) begin
        out_log[out_n] = tdata;
        out_n = out_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_hdr(input logic [7:0] ft, input logic [9:0] len,
                                          input logic [3:0] fbe, input logic [3:0] lbe,
                                          input logic [63:0] addr);
    logic [127:0] h;
    h = '0;
    h[127:120] = ft;
    h[105:96]  = len;
    h[71:68]   = lbe;
    h[67:64]   = fbe;
    if (ft == 8'h60) begin
      h[63:32] = addr[63:32];
      h[31:0]  = addr[31:0];
    end else begin
      h[63:32] = addr[31:0];
    end
    return h;
  endfunction

  // Presents one beat and returns at #1 after the edge on which it transferred.
  task automatic beat(input logic [127:0] h, input logic [31:0] d,
                      input logic s, input logic e);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    hdr = h; data = d; sop = s; eop = e; valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (ready) ok = 1;
      @(posedge clk); #1;
    end
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    if (!ok) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic db_wr(input logic [31:0] vec);
    beat(mk_hdr(8'h40, 10'd1, 4'hF, 4'h0, DB), vec, 1'b1, 1'b1);
  endtask

  int irq0, drop0, out0;

  initial begin
    // Reset state
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_stat_irq", stat_irq, 0);
    chk("rst_stat_drop", stat_drop, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", ready, 1);
    chk("tlast", tlast, 1);

    // 3DW doorbell, one cycle latency
    db_wr(32'h25);
    chk("t1_tvalid", tvalid, 1);
    chk("t1_tdata", tdata, 11'h25);
    chk("t1_stat_irq", stat_irq, 1);
    chk("t1_stat_drop", stat_drop, 0);
    @(posedge clk); #1;
    chk("t1_irq_single", stat_irq, 0);
    tready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t1_out_n", out_n, 1);
    chk("t1_out0", out_log[0], 11'h25);
    chk("t1_irq_cnt", irq_cnt, 1);

    // 4DW write with zero upper address, then a mismatching upper address
    irq0 = irq_cnt; drop0 = drop_cnt; out0 = out_n;
    beat(mk_hdr(8'h60, 10'd1, 4'hF, 4'h0, DB), 32'h7FF, 1'b1, 1'b1);
    beat(mk_hdr(8'h60, 10'd1, 4'hF, 4'h0, 64'h1_FEE0_1000), 32'h12, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("t2_out_n", out_n - out0, 1);
    chk("t2_vec", out_log[out0], 11'h7FF);
    chk("t2_irq", irq_cnt - irq0, 1);
    chk("t2_drop", drop_cnt - drop0, 1);

    // 16-DW write to the doorbell: dropped in full, next write still works
    irq0 = irq_cnt; drop0 = drop_cnt; out0 = out_n;
    beat(mk_hdr(8'h40, 10'd16, 4'hF, 4'hF, DB), 32'h5, 1'b1, 1'b0);
    beat('0, 32'h6, 1'b0, 1'b0);
    beat('0, 32'h7, 1'b0, 1'b0);
    beat('0, 32'h8, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("t3_drop", drop_cnt - drop0, 1);
    chk("t3_no_vec", out_n - out0, 0);
    db_wr(32'h3);
    repeat (3) @(posedge clk); #1;
    chk("t3_after_vec_n", out_n - out0, 1);
    chk("t3_after_vec", out_log[out0], 11'h3);
    chk("t3_irq", irq_cnt - irq0, 1);

    // Backpressure: 16 fill the FIFO, ready falls, rest flow after release
    tready = 1'b0;
    irq0 = irq_cnt; out0 = out_n;
    for (int v = 0; v < 16; v++) db_wr(v);
    chk("t4_ready_full", ready, 0);
    repeat (5) @(posedge clk); #1;
    chk("t4_ready_held", ready, 0);
    chk("t4_no_out", out_n - out0, 0);
    tready = 1'b1;
    @(posedge clk); #1;
    chk("t4_ready_rise", ready, 1);
    for (int v = 16; v < 20; v++) db_wr(v);
    repeat (30) @(posedge clk); #1;
    chk("t4_out_n", out_n - out0, 20);
    chk("t4_irq", irq_cnt - irq0, 20);
    begin
      int bad;
      bad = 0;
      for (int v = 0; v < 20; v++)
        if (out_log[out0 + v] !== 11'(v)) bad++;
      chk("t4_order", bad, 0);
    end

    // Assorted mismatches
    irq0 = irq_cnt; drop0 = drop_cnt; out0 = out_n;
    db_wr(32'h800);
    beat(mk_hdr(8'h40, 10'd1, 4'h3, 4'h0, DB), 32'h4, 1'b1, 1'b1);
    db_enable = 1'b0;
    db_wr(32'h4);
    db_enable = 1'b1;
    beat(mk_hdr(8'h00, 10'd1, 4'hF, 4'h0, DB), 32'h4, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("t5_drop", drop_cnt - drop0, 4);
    chk("t5_irq", irq_cnt - irq0, 0);
    chk("t5_no_vec", out_n - out0, 0);

    // Reset with queued vectors and the FSM in DROP
    tready = 1'b0;
    for (int v = 0; v < 5; v++) db_wr(32'h40 + v);
    beat(mk_hdr(8'h40, 10'd2, 4'hF, 4'hF, DB), 32'h1, 1'b1, 1'b0);
    chk("t6_queued", tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", tvalid, 0);
    chk("t6_rst_ready", ready, 0);
    chk("t6_rst_tdata", tdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_ready_rise", ready, 1);
    irq0 = irq_cnt; drop0 = drop_cnt; out0 = out_n;
    tready = 1'b1;
    beat('0, 32'h2, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("t6_stray_drop", drop_cnt - drop0, 0);
    chk("t6_flushed", out_n - out0, 0);
    db_wr(32'h155);
    repeat (3) @(posedge clk); #1;
    chk("t6_one_vec", out_n - out0, 1);
    chk("t6_vec", out_log[out0], 11'h155);
    chk("t6_irq", irq_cnt - irq0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stalled expected completion");
    $fatal(1, "timeout");
  end

endmodule
